// File: rtl/mapa_arbitro.sv
// Map RAM arbiter: VGA reads, a full-map clear sweep and round-robin game
// requesters share one single-port RAM, with at most one access per cycle.
module mapa_arbitro #(
  parameter int MAPA_WIDTH  = 40,
  parameter int MAPA_HEIGHT = 30,
  parameter int XW          = 6,
  parameter int YW          = 5,
  parameter int AW          = 11
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            vga_read,
  input  logic [9:0]      vga_x,
  input  logic [9:0]      vga_y,
  output logic [3:0]      vga_data,
  output logic            vga_valid,
  input  logic [2:0]      req,
  input  logic [2:0]      req_we,
  input  logic [3*XW-1:0] req_x,
  input  logic [3*YW-1:0] req_y,
  input  logic [11:0]     req_wdata,
  output logic [2:0]      gnt,
  output logic            req_err,
  output logic [3:0]      rdata,
  output logic            rvalid,
  output logic [1:0]      rid,
  input  logic            clear_start,
  output logic            clear_busy,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [3:0]      mem_wdata,
  input  logic [3:0]      mem_rdata
);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  localparam int unsigned N_CELLS = MAPA_WIDTH * MAPA_HEIGHT;
  localparam logic [AW-1:0] LAST_ADDR = AW'(N_CELLS - 1);

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]    r_rr_ptr, w_rr_nxt;
  logic          r_vga_valid, r_vga_hit, r_rvalid;
  logic [1:0]    r_rid;

  logic          w_vga_ok;
  logic [AW-1:0] w_vga_addr;
  logic [1:0]    w_idx, w_win;
  logic          w_win_vld;
  logic [XW-1:0] w_gx;
  logic [YW-1:0] w_gy;
  logic          w_g_in;
  logic [AW-1:0] w_g_addr;
  logic          w_game_rd;

  assign w_vga_ok   = (int'(vga_x) < MAPA_WIDTH) && (int'(vga_y) < MAPA_HEIGHT);
  assign w_vga_addr = AW'(int'(vga_y) * MAPA_WIDTH + int'(vga_x));

  // First pending requester at or after the round-robin pointer
  always_comb begin
    w_win     = '0;
    w_win_vld = 1'b0;
    w_idx     = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      w_idx = 2'((32'(r_rr_ptr) + k) % 32'd3);
      if (!w_win_vld && req[w_idx]) begin
        w_win_vld = 1'b1;
        w_win     = w_idx;
      end
    end
  end

  assign w_gx     = req_x[w_win*XW +: XW];
  assign w_gy     = req_y[w_win*YW +: YW];
  assign w_g_in   = (int'(w_gx) < MAPA_WIDTH) && (int'(w_gy) < MAPA_HEIGHT);
  assign w_g_addr = AW'(int'(w_gy) * MAPA_WIDTH + int'(w_gx));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rr_nxt    = r_rr_ptr;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    gnt         = '0;
    req_err     = 1'b0;
    w_game_rd   = 1'b0;
    // Combinational outputs are forced low while reset is held
    if (!reset) begin
      if (vga_read) begin
        if (w_vga_ok) begin
          mem_en   = 1'b1;
          mem_addr = w_vga_addr;
        end
      end else if (r_state == S_CLEAR) begin
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = r_cnt;
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end else if (w_win_vld) begin
        gnt[w_win] = 1'b1;
        w_rr_nxt   = (w_win == 2'd2) ? 2'd0 : w_win + 2'd1;
        if (w_g_in) begin
          mem_en    = 1'b1;
          mem_we    = req_we[w_win];
          mem_addr  = w_g_addr;
          mem_wdata = req_wdata[w_win*4 +: 4];
          w_game_rd = !req_we[w_win];
        end else begin
          req_err = 1'b1;
        end
      end
      if (r_state == S_IDLE && clear_start) begin
        w_state_nxt = S_CLEAR;
        w_cnt_nxt   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rr_ptr    <= '0;
      r_vga_valid <= 1'b0;
      r_vga_hit   <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rid       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_vga_valid <= vga_read;
      r_vga_hit   <= vga_read && w_vga_ok;
      r_rvalid    <= w_game_rd;
      if (w_game_rd) r_rid <= w_win;
    end
  end

  assign vga_valid  = r_vga_valid;
  assign vga_data   = r_vga_hit ? mem_rdata : '0;
  assign rvalid     = r_rvalid;
  assign rdata      = r_rvalid ? mem_rdata : '0;
  assign rid        = r_rid;
  assign clear_busy = (r_state == S_CLEAR);

endmodule

// File: tb/tb_mapa_arbitro.sv
// Scoreboard bench for mapa_arbitro: a cell-array map model predicts every
// access and queues expected VGA/game read responses for a separate monitor.
module tb_mapa_arbitro;
  localparam int W  = 40;
  localparam int H  = 30;
  localparam int XW = 6;
  localparam int YW = 5;
  localparam int AW = 11;
  localparam int N  = W * H;

  logic            clk = 1'b0;
  logic            reset;
  logic            vga_read;
  logic [9:0]      vga_x, vga_y;
  logic [3:0]      vga_data;
  logic            vga_valid;
  logic [2:0]      req, req_we;
  logic [3*XW-1:0] req_x;
  logic [3*YW-1:0] req_y;
  logic [11:0]     req_wdata;
  logic [2:0]      gnt;
  logic            req_err;
  logic [3:0]      rdata;
  logic            rvalid;
  logic [1:0]      rid;
  logic            clear_start;
  logic            clear_busy;
  logic            mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [3:0]      mem_wdata;
  logic [3:0]      mem_rdata = 4'h0;

  always #5 clk = ~clk;

  mapa_arbitro #(.MAPA_WIDTH(W), .MAPA_HEIGHT(H), .XW(XW), .YW(YW), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .vga_read(vga_read), .vga_x(vga_x), .vga_y(vga_y),
    .vga_data(vga_data), .vga_valid(vga_valid),
    .req(req), .req_we(req_we), .req_x(req_x), .req_y(req_y), .req_wdata(req_wdata),
    .gnt(gnt), .req_err(req_err), .rdata(rdata), .rvalid(rvalid), .rid(rid),
    .clear_start(clear_start), .clear_busy(clear_busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Physical RAM with one-cycle read latency
  logic [3:0] ram [0:2047];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  typedef struct { int rid; int data; } rd_t;

  int   checks = 0;
  int   errors = 0;
  int   gold [0:2047];
  int   vq[$];
  rd_t  gq[$];
  bit   m_clr = 0;
  int   m_idx = 0;
  int   m_rr  = 0;
  int   g_last = -1;
  int   mode = 1;       // 0 hold requests, 1 drop after grant, 2 random
  int   busy_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input bit we, input int x, input int y, input int wd);
    req[i] = 1'b1;
    req_we[i] = we;
    req_x[i*XW +: XW] = XW'(x);
    req_y[i*YW +: YW] = YW'(y);
    req_wdata[i*4 +: 4] = 4'(wd);
  endtask

  task automatic rand_req(input int i);
    set_req(i, bit'($urandom_range(1, 0)), int'($urandom_range(45, 0)),
            int'($urandom_range(33, 0)), int'($urandom_range(15, 0)));
  endtask

  // Predicts this cycle's access from the current inputs and checks it
  task automatic model_check();
    int eg, een, ewe, eaddr, ewd, eerr, a, x, y;
    bit busy0;
    busy0 = m_clr;
    eg = 0; een = 0; ewe = 0; eaddr = 0; ewd = 0; eerr = 0;
    g_last = -1;
    chk("clear_busy", int'(clear_busy), int'(busy0));
    if (vga_read) begin
      if (int'(vga_x) < W && int'(vga_y) < H) begin
        a = int'(vga_y) * W + int'(vga_x);
        een = 1; eaddr = a;
        vq.push_back(gold[a]);
      end else begin
        vq.push_back(0);
      end
    end else if (m_clr) begin
      een = 1; ewe = 1; eaddr = m_idx; ewd = 0;
      gold[m_idx] = 0;
      m_idx++;
      if (m_idx == N) m_clr = 0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        int i;
        i = (m_rr + k) % 3;
        if (g_last < 0 && req[i]) g_last = i;
      end
      if (g_last >= 0) begin
        eg = 1 << g_last;
        m_rr = (g_last + 1) % 3;
        x = int'(req_x[g_last*XW +: XW]);
        y = int'(req_y[g_last*YW +: YW]);
        if (x < W && y < H) begin
          a = y * W + x;
          een = 1; ewe = int'(req_we[g_last]); eaddr = a;
          ewd = int'(req_wdata[g_last*4 +: 4]);
          if (ewe != 0) gold[a] = ewd;
          else gq.push_back('{rid: g_last, data: gold[a]});
        end else begin
          eerr = 1;
        end
      end
    end
    if (!busy0 && clear_start) begin
      m_clr = 1;
      m_idx = 0;
    end
    chk("gnt", int'(gnt), eg);
    chk("req_err", int'(req_err), eerr);
    chk("mem_en", int'(mem_en), een);
    if (een != 0) begin
      chk("mem_we", int'(mem_we), ewe);
      chk("mem_addr", int'(mem_addr), eaddr);
      if (ewe != 0) chk("mem_wdata", int'(mem_wdata), ewd);
    end
  endtask

  task automatic step(input bit vr, input int vx, input int vy, input bit cs);
    @(negedge clk);
    if (g_last >= 0) begin
      if (mode == 2 && $urandom_range(1, 0) == 1) rand_req(g_last);
      else if (mode != 0) req[g_last] = 1'b0;
    end
    if (mode == 2)
      for (int i = 0; i < 3; i++)
        if (!req[i] && $urandom_range(9, 0) < 3) rand_req(i);
    vga_read = vr;
    vga_x = 10'(vx);
    vga_y = 10'(vy);
    clear_start = cs;
    #1;
    model_check();
    if (clear_busy) busy_cnt++;
  endtask

  // Move into the next cycle so direct input changes land in an unchecked window
  task automatic sync_cycle();
    @(posedge clk);
    #2;
    g_last = -1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_vga_valid"}, int'(vga_valid), 0);
    chk({tag, "_vga_data"}, int'(vga_data), 0);
    chk({tag, "_gnt"}, int'(gnt), 0);
    chk({tag, "_req_err"}, int'(req_err), 0);
    chk({tag, "_rvalid"}, int'(rvalid), 0);
    chk({tag, "_rdata"}, int'(rdata), 0);
    chk({tag, "_rid"}, int'(rid), 0);
    chk({tag, "_clear_busy"}, int'(clear_busy), 0);
    chk({tag, "_mem_en"}, int'(mem_en), 0);
    chk({tag, "_mem_we"}, int'(mem_we), 0);
    chk({tag, "_mem_addr"}, int'(mem_addr), 0);
    chk({tag, "_mem_wdata"}, int'(mem_wdata), 0);
  endtask

  // Monitor: every read response must match the head of its queue
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      if (vga_valid) begin
        if (vq.size() == 0) chk("vga_valid_unexpected", 1, 0);
        else chk("vga_data", int'(vga_data), vq.pop_front());
      end else if (vq.size() != 0) begin
        chk("vga_valid_missing", 0, 1);
        vq.delete();
      end
      if (rvalid) begin
        if (gq.size() == 0) chk("rvalid_unexpected", 1, 0);
        else begin
          rd_t e;
          e = gq.pop_front();
          chk("rdata", int'(rdata), e.data);
          chk("rid", int'(rid), e.rid);
        end
      end else if (gq.size() != 0) begin
        chk("rvalid_missing", 0, 1);
        gq.delete();
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int seq [6];
    seq = '{1, 2, 4, 1, 2, 4};
    reset = 1'b1;
    vga_read = 0; vga_x = '0; vga_y = '0; clear_start = 0;
    req = '0; req_we = '0; req_x = '0; req_y = '0; req_wdata = '0;
    for (int i = 0; i < 2048; i++) begin
      ram[i] = 4'($urandom_range(15, 0));
      gold[i] = int'(ram[i]);
    end
    ram[410] = 4'b0010;
    gold[410] = 2;
    #3;
    check_all_zero("reset0");
    @(negedge clk);
    reset = 1'b0;

    // VGA reads: in range and column out of range
    step(1, 10, 10, 0);
    chk("vga_addr_410", int'(mem_addr), 410);
    step(1, 40, 0, 0);
    chk("vga_oor_no_access", int'(mem_en), 0);
    step(0, 0, 0, 0);

    // Round-robin with all three reading continuously
    sync_cycle();
    mode = 0;
    set_req(0, 0, 1, 2, 0);
    set_req(1, 0, 3, 4, 0);
    set_req(2, 0, 5, 6, 0);
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 0, 0);
      chk("rr_seq", int'(gnt), seq[k]);
    end
    sync_cycle();
    mode = 1;
    req = '0;

    // VGA blocks game access
    set_req(1, 0, 7, 8, 0);
    for (int k = 0; k < 5; k++) begin
      step(1, 2, 2, 0);
      chk("vga_blocks_gnt", int'(gnt), 0);
    end
    step(0, 0, 0, 0);
    chk("gnt_after_vga", int'(gnt), 2);

    // Corner write and out-of-range write
    sync_cycle();
    req = '0;
    set_req(0, 1, 39, 29, 13);
    step(0, 0, 0, 0);
    chk("corner_addr", int'(mem_addr), 1199);
    chk("corner_we", int'(mem_we), 1);
    sync_cycle();
    req = '0;
    set_req(2, 1, 0, 30, 5);
    step(0, 0, 0, 0);
    chk("oor_gnt", int'(gnt), 4);
    chk("oor_err", int'(req_err), 1);
    chk("oor_no_access", int'(mem_en), 0);
    sync_cycle();
    req = '0;
    step(1, 39, 29, 0);
    step(0, 0, 0, 0);

    // Random traffic
    mode = 2;
    for (int k = 0; k < 300; k++)
      step(bit'($urandom_range(9, 0) < 3), int'($urandom_range(44, 0)),
           int'($urandom_range(33, 0)), 0);
    sync_cycle();
    mode = 1;
    req = '0;

    // Clear sweep, no VGA, request left pending throughout
    busy_cnt = 0;
    step(0, 0, 0, 1);
    sync_cycle();
    set_req(0, 0, 1, 1, 0);
    for (int k = 0; k < 1205; k++) step(0, 0, 0, 0);
    chk("clear_len", busy_cnt, N);

    // Repopulate, then clear with three interleaved VGA reads
    sync_cycle();
    mode = 2;
    for (int k = 0; k < 100; k++) step(0, 0, 0, 0);
    sync_cycle();
    mode = 1;
    req = '0;
    busy_cnt = 0;
    step(0, 0, 0, 1);
    for (int k = 0; k < 1210; k++)
      step(bit'(k == 100 || k == 500 || k == 900), int'($urandom_range(W - 1, 0)),
           int'($urandom_range(H - 1, 0)), 0);
    chk("clear_len_vga", busy_cnt, N + 3);

    // Reset mid-clear at cnt=500 with a VGA read in flight
    step(0, 0, 0, 1);
    while (m_idx < 500) step(0, 0, 0, 0);
    step(1, 5, 5, 0);
    sync_cycle();
    set_req(0, 0, 2, 2, 0);
    vga_read = 1'b1;
    reset = 1'b1;
    m_clr = 0; m_idx = 0; m_rr = 0;
    vq.delete();
    gq.delete();
    #1;
    check_all_zero("reset_mid");
    vga_read = 1'b0;
    req = '0;
    @(negedge clk);
    reset = 1'b0;

    // Restarted sweep begins at address 0 and runs the full length
    busy_cnt = 0;
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("restart_addr0", int'(mem_addr), 0);
    for (int k = 0; k < 1204; k++) step(0, 0, 0, 0);
    chk("clear_len_restart", busy_cnt, N);
    for (int k = 0; k < 4; k++)
      step(1, int'($urandom_range(W - 1, 0)), int'($urandom_range(H - 1, 0)), 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
